// File: rtl/lcd_reader_if.sv
// Host-side request/response channel of the LCD read controller.
// The master issues reads; the slave (lcd_reader) returns the byte and status.
interface lcd_reader_if;
  logic       start;
  logic       rs_sel;
  logic       poll;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       timeout;

  modport master (
    output start, rs_sel, poll,
    input  rdata, rvalid, busy, timeout
  );

  modport slave (
    input  start, rs_sel, poll,
    output rdata, rvalid, busy, timeout
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780-style 4-bit read controller: single status/data reads, plus a busy-poll
// mode that repeats status reads until BF clears or POLL_MAX reads have been made.
module lcd_reader #(
  parameter int unsigned T_SU     = 3,
  parameter int unsigned T_EH     = 12,
  parameter int unsigned T_SAMP   = 10,
  parameter int unsigned T_GAP    = 50,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned POLL_MAX = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  lcd_reader_if.slave      host,
  input  logic [3:0]       sf_d_in,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             bus_rd
);

  localparam int unsigned CW  = 8;
  localparam int unsigned PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_EH1, S_GAP1, S_EH2, S_HOLD, S_CHECK, S_PGAP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
  logic             rs_q, rs_d;
  logic             poll_q, poll_d;
  logic [3:0]       upper_q, upper_d;
  logic [3:0]       lower_q, lower_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             timeout_q, timeout_d;
  logic             rvalid_q, rvalid_d;
  logic             busy_q, busy_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_rw_q, lcd_rw_d;
  logic             last_c;

  // Terminal count for the timed states (cycles in state minus one).
  function automatic logic [CW-1:0] state_len(input state_t s);
    case (s)
      S_SETUP:        return CW'(T_SU - 1);
      S_EH1, S_EH2:   return CW'(T_EH - 1);
      S_GAP1, S_PGAP: return CW'(T_GAP - 1);
      S_HOLD:         return CW'(T_HOLD - 1);
      default:        return CW'(0);
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poll_cnt_q <= '0;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      upper_q    <= 4'h0;
      lower_q    <= 4'h0;
      rdata_q    <= 8'h00;
      timeout_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      rs_q       <= rs_d;
      poll_q     <= poll_d;
      upper_q    <= upper_d;
      lower_q    <= lower_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      rvalid_q   <= rvalid_d;
      busy_q     <= busy_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    rs_d       = rs_q;
    poll_d     = poll_q;
    upper_d    = upper_q;
    lower_d    = lower_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    last_c     = (cnt_q == state_len(state_q));

    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          rs_d       = host.rs_sel & ~host.poll;
          poll_d     = host.poll;
          poll_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: if (last_c) state_d = S_EH1;
      S_EH1: begin
        if (cnt_q == CW'(T_SAMP)) upper_d = sf_d_in;
        if (last_c) state_d = S_GAP1;
      end
      S_GAP1: if (last_c) state_d = S_EH2;
      S_EH2: begin
        if (cnt_q == CW'(T_SAMP)) lower_d = sf_d_in;
        if (last_c) state_d = S_HOLD;
      end
      S_HOLD: if (last_c) state_d = poll_q ? S_CHECK : S_DONE;
      S_CHECK: begin
        // upper_q[3] is BF of the byte just read.
        if (upper_q[3] && (poll_cnt_q < PCW'(POLL_MAX - 1))) begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
          state_d    = S_PGAP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PGAP: if (last_c) state_d = S_SETUP;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      rdata_d   = {upper_q, lower_q};
      timeout_d = (state_q == S_CHECK) && upper_q[3];
    end

    cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CW'(1);

    // Outputs registered from the next state so they line up with state_q.
    lcd_rw_d = state_d inside {S_SETUP, S_EH1, S_GAP1, S_EH2, S_HOLD};
    lcd_e_d  = state_d inside {S_EH1, S_EH2};
    lcd_rs_d = lcd_rw_d & rs_d;
    rvalid_d = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  assign LCD_E        = lcd_e_q;
  assign LCD_RS       = lcd_rs_q;
  assign LCD_RW       = lcd_rw_q;
  assign bus_rd       = lcd_rw_q;
  assign host.rdata   = rdata_q;
  assign host.rvalid  = rvalid_q;
  assign host.busy    = busy_q;
  assign host.timeout = timeout_q;

endmodule
